store_issue_port: RTL and testbench

Drain side of the store queue. Pops released stores from the store queue's output port (`sq.valid` / `sq.data_out` / `sq.pop`) into a one-entry holding register and presents them as write requests to the shared data-memory port. It tracks write completions and arbitrates against pending loads, with a starvation guard. It reports when all stores have fully drained, for fence/AMO sequencing in the load-store unit.

---
 rtl/store_issue_port.sv | 103 ++++++++++
 tb/tb_store_issue_port.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/store_issue_port.sv
// Store-queue drain: one-entry holding register feeding the shared data-memory
// write port, with outstanding-write tracking and a load-starvation guard.
module store_issue_port #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int STARVE_LIMIT    = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sq_valid,
    input  logic [31:0] sq_addr,
    input  logic [3:0]  sq_be,
    input  logic [31:0] sq_data,
    output logic        sq_pop,
    input  logic        load_pending,
    output logic        store_priority,
    output logic        wr_req,
    output logic [31:0] wr_addr,
    output logic [3:0]  wr_be,
    output logic [31:0] wr_data,
    input  logic        wr_ack,
    input  logic        wr_done,
    output logic        stores_drained,
    output logic [3:0]  outstanding
);
    localparam logic [3:0] CapCnt    = 4'(MAX_OUTSTANDING);
    localparam logic [7:0] StarveMax = 8'(STARVE_LIMIT);

    logic        hold_valid_q, hold_valid_d;
    logic [29:0] hold_addr_q, hold_addr_d;
    logic [3:0]  hold_be_q, hold_be_d;
    logic [31:0] hold_data_q, hold_data_d;
    logic [3:0]  out_cnt_q, out_cnt_d;
    logic [7:0]  starve_cnt_q, starve_cnt_d;
    logic        blocked, cap, accept;
    logic        addr_lo_unused;

    // Writes are word-granular; the byte offset is already encoded in sq_be.
    assign addr_lo_unused = ^sq_addr[1:0];

    always_comb begin
        store_priority = (starve_cnt_q == StarveMax) && hold_valid_q;
        blocked        = load_pending && !store_priority;
        cap            = (out_cnt_q == CapCnt);
        wr_req         = hold_valid_q && !blocked && !cap;
        accept         = wr_req && wr_ack;
        sq_pop         = sq_valid && (!hold_valid_q || accept) && !rst;
        wr_addr        = {hold_addr_q, 2'b00};
        wr_be          = hold_be_q;
        wr_data        = hold_data_q;
        stores_drained = !hold_valid_q && (out_cnt_q == 4'd0);
        outstanding    = out_cnt_q;

        hold_valid_d = hold_valid_q;
        hold_addr_d  = hold_addr_q;
        hold_be_d    = hold_be_q;
        hold_data_d  = hold_data_q;
        if (sq_pop) begin
            hold_valid_d = 1'b1;
            hold_addr_d  = sq_addr[31:2];
            hold_be_d    = sq_be;
            hold_data_d  = sq_data;
        end else if (accept) begin
            hold_valid_d = 1'b0;
        end

        out_cnt_d = out_cnt_q;
        if (accept && !wr_done)
            out_cnt_d = out_cnt_q + 4'd1;
        else if (wr_done && !accept && out_cnt_q != 4'd0)
            out_cnt_d = out_cnt_q - 4'd1;

        // Cap stalls are not load contention, so only 'blocked' ages the store.
        starve_cnt_d = starve_cnt_q;
        if (accept || !hold_valid_q)
            starve_cnt_d = 8'd0;
        else if (blocked && starve_cnt_q != StarveMax)
            starve_cnt_d = starve_cnt_q + 8'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_valid_q <= 1'b0;
            hold_addr_q  <= '0;
            hold_be_q    <= '0;
            hold_data_q  <= '0;
            out_cnt_q    <= '0;
            starve_cnt_q <= '0;
        end else begin
            hold_valid_q <= hold_valid_d;
            hold_addr_q  <= hold_addr_d;
            hold_be_q    <= hold_be_d;
            hold_data_q  <= hold_data_d;
            out_cnt_q    <= out_cnt_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

`ifndef SYNTHESIS
    a_no_done_underflow: assert property (@(posedge clk) disable iff (rst)
        !(wr_done && out_cnt_q == 4'd0));
`endif

endmodule

// File: tb/tb_store_issue_port.sv
// Directed bench: instance a uses default parameters, instance b uses
// MAX_OUTSTANDING=2 / STARVE_LIMIT=3 for the cap and starvation cases.
module tb_store_issue_port;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    logic        a_sq_valid = 0, a_load = 0, a_ack = 0, a_done = 0;
    logic [31:0] a_addr = 0, a_data = 0;
    logic [3:0]  a_be = 0;
    logic        a_pop, a_prio, a_req, a_drained;
    logic [31:0] a_waddr, a_wdata;
    logic [3:0]  a_wbe, a_out;

    logic        b_sq_valid = 0, b_load = 0, b_ack = 0, b_done = 0;
    logic [31:0] b_addr = 0, b_data = 0;
    logic [3:0]  b_be = 0;
    logic        b_pop, b_prio, b_req, b_drained;
    logic [31:0] b_waddr, b_wdata;
    logic [3:0]  b_wbe, b_out;

    store_issue_port dut_a (
        .clk(clk), .rst(rst), .sq_valid(a_sq_valid), .sq_addr(a_addr), .sq_be(a_be),
        .sq_data(a_data), .sq_pop(a_pop), .load_pending(a_load), .store_priority(a_prio),
        .wr_req(a_req), .wr_addr(a_waddr), .wr_be(a_wbe), .wr_data(a_wdata),
        .wr_ack(a_ack), .wr_done(a_done), .stores_drained(a_drained), .outstanding(a_out)
    );

    store_issue_port #(.MAX_OUTSTANDING(2), .STARVE_LIMIT(3)) dut_b (
        .clk(clk), .rst(rst), .sq_valid(b_sq_valid), .sq_addr(b_addr), .sq_be(b_be),
        .sq_data(b_data), .sq_pop(b_pop), .load_pending(b_load), .store_priority(b_prio),
        .wr_req(b_req), .wr_addr(b_waddr), .wr_be(b_wbe), .wr_data(b_wdata),
        .wr_ack(b_ack), .wr_done(b_done), .stores_drained(b_drained), .outstanding(b_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; checks happen 3 units later.
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic a_store(input logic v, input logic [31:0] ad, input logic [3:0] be,
                           input logic [31:0] d);
        a_sq_valid = v; a_addr = ad; a_be = be; a_data = d;
    endtask

    task automatic b_store(input logic v, input logic [31:0] d);
        b_sq_valid = v; b_addr = 32'h3000; b_be = 4'hF; b_data = d;
    endtask

    initial begin
        // Reset values; sq_pop must be suppressed during reset.
        a_store(1, 32'h1003, 4'b1000, 32'hAB00_0000);
        settle();
        chk("rst_pop", a_pop, 0);
        chk("rst_req", a_req, 0);
        chk("rst_prio", a_prio, 0);
        chk("rst_drained", a_drained, 1);
        chk("rst_out", a_out, 0);
        nxt();
        rst = 0;
        a_ack = 1;

        // Single store.
        settle();
        chk("s1_pop_c0", a_pop, 1);
        chk("s1_req_c0", a_req, 0);
        nxt(); a_store(0, 0, 0, 0); settle();
        chk("s1_req_c1", a_req, 1);
        chk("s1_addr", a_waddr, 32'h1000);
        chk("s1_be", a_wbe, 4'b1000);
        chk("s1_data", a_wdata, 32'hAB00_0000);
        nxt(); settle();
        chk("s1_out_c2", a_out, 1);
        chk("s1_req_c2", a_req, 0);
        chk("s1_drn_c2", a_drained, 0);
        nxt(); settle();
        nxt(); a_done = 1; settle();
        chk("s1_drn_c4", a_drained, 0);
        nxt(); a_done = 0; settle();
        chk("s1_drn_c5", a_drained, 1);
        chk("s1_out_c5", a_out, 0);

        // Back-to-back streaming of three stores.
        nxt(); a_store(1, 32'h2000, 4'hF, 32'hD000_0000); settle();
        chk("bb_pop0", a_pop, 1);
        nxt(); a_store(1, 32'h2004, 4'hF, 32'hD000_0001); settle();
        chk("bb_pop1", a_pop, 1);
        chk("bb_data0", a_wdata, 32'hD000_0000);
        nxt(); a_store(1, 32'h2008, 4'hF, 32'hD000_0002); settle();
        chk("bb_pop2", a_pop, 1);
        chk("bb_data1", a_wdata, 32'hD000_0001);
        chk("bb_addr1", a_waddr, 32'h2004);
        chk("bb_out1", a_out, 1);
        nxt(); a_store(0, 0, 0, 0); settle();
        chk("bb_pop3", a_pop, 0);
        chk("bb_req3", a_req, 1);
        chk("bb_data2", a_wdata, 32'hD000_0002);
        chk("bb_out2", a_out, 2);
        nxt(); settle();
        chk("bb_out3", a_out, 3);
        chk("bb_req4", a_req, 0);

        // Retire one, then accept and wr_done together at out_cnt == 2.
        a_done = 1;
        nxt(); a_done = 0; a_store(1, 32'h2100, 4'h3, 32'h0000_BEEF); settle();
        chk("sim_out_pre", a_out, 2);
        chk("sim_pop", a_pop, 1);
        nxt(); a_store(0, 0, 0, 0); a_done = 1; settle();
        chk("sim_req", a_req, 1);
        nxt(); a_done = 0; settle();
        chk("sim_out", a_out, 2);
        a_done = 1;
        nxt(); nxt(); a_done = 0; settle();
        chk("sim_drained", a_drained, 1);

        // Outstanding cap on b (MAX_OUTSTANDING = 2).
        b_ack = 1;
        b_store(1, 32'hC000_0000); settle();
        chk("cap_pop0", b_pop, 1);
        nxt(); b_store(1, 32'hC000_0001); settle();
        chk("cap_pop1", b_pop, 1);
        nxt(); b_store(1, 32'hC000_0002); settle();
        chk("cap_pop2", b_pop, 1);
        chk("cap_req2", b_req, 1);
        nxt(); b_store(1, 32'hC000_0003); settle();
        chk("cap_out", b_out, 2);
        chk("cap_req_low", b_req, 0);
        chk("cap_pop_held", b_pop, 0);
        chk("cap_hold_data", b_wdata, 32'hC000_0002);
        nxt(); b_store(0, 0); b_done = 1; settle();
        chk("cap_req_done_cyc", b_req, 0);
        nxt(); b_done = 0; settle();
        chk("cap_req_resume", b_req, 1);
        chk("cap_resume_data", b_wdata, 32'hC000_0002);
        nxt(); settle();
        chk("cap_out_refill", b_out, 2);
        b_done = 1;
        nxt(); nxt(); b_done = 0; settle();
        chk("cap_drained", b_drained, 1);

        // Load starvation on b (STARVE_LIMIT = 3).
        b_load = 1;
        b_store(1, 32'h5151_0000); settle();
        chk("stv_pop", b_pop, 1);
        nxt(); b_store(0, 0); settle();
        chk("stv_req1", b_req, 0);
        chk("stv_prio1", b_prio, 0);
        nxt(); settle();
        chk("stv_req2", b_req, 0);
        nxt(); settle();
        chk("stv_req3", b_req, 0);
        chk("stv_prio3", b_prio, 0);
        nxt(); settle();
        chk("stv_prio4", b_prio, 1);
        chk("stv_req4", b_req, 1);
        chk("stv_data", b_wdata, 32'h5151_0000);
        nxt(); settle();
        chk("stv_prio_clr", b_prio, 0);
        chk("stv_req5", b_req, 0);
        b_load = 0; b_done = 1;
        nxt(); b_done = 0; settle();
        chk("stv_drained", b_drained, 1);

        // Asynchronous reset with a held store and three outstanding on a.
        a_store(1, 32'h4000, 4'hF, 32'h1111_0000); a_ack = 1;
        nxt(); a_store(1, 32'h4004, 4'hF, 32'h1111_0001);
        nxt(); a_store(1, 32'h4008, 4'hF, 32'h1111_0002);
        nxt(); a_store(1, 32'h400C, 4'hF, 32'h1111_0003);
        nxt(); a_store(0, 0, 0, 0); a_ack = 0; settle();
        chk("ar_pre_out", a_out, 3);
        chk("ar_pre_req", a_req, 1);
        chk("ar_pre_drn", a_drained, 0);
        #1 rst = 1;
        #1;
        chk("ar_req", a_req, 0);
        chk("ar_out", a_out, 0);
        chk("ar_drained", a_drained, 1);
        nxt(); rst = 0; settle();
        chk("ar_post_drn", a_drained, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end
endmodule
